// File: rtl/regfile_mp.sv
// Multi-ported integer register file with optional write-to-read bypass and a
// per-register busy scoreboard; register 0 reads as zero and is never busy.
module regfile_mp #(
    parameter  int unsigned XLEN   = 64,
    parameter  int unsigned NREGS  = 32,
    parameter  int unsigned NUM_RD = 2,
    parameter  int unsigned NUM_WR = 2,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
    input  logic                     iss_en_i,
    input  logic [AW-1:0]            iss_addr_i,
    output logic [NREGS-1:0]         busy_o
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;

    // Ascending port order lets the highest-index writer win on conflicts.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
                busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        // A new issue supersedes a completing writer to the same register.
        if (iss_en_i && (iss_addr_i != '0)) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin : read_ports
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbsy;
        logic            hit;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            ra   = rd_addr_i[p*AW +: AW];
            rdat = regs_q[ra];
            rbsy = busy_q[ra];
            hit  = 1'b0;
            // Forwarding is suppressed while reset is held so reads show stored state.
            if ((BYPASS != 0) && reset) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == ra)) begin
                        rdat = wr_data_i[w*XLEN +: XLEN];
                        hit  = 1'b1;
                    end
                end
            end
            if (hit && !(iss_en_i && (iss_addr_i == ra))) begin
                rbsy = 1'b0;
            end
            if (ra == '0) begin
                rdat = '0;
                rbsy = 1'b0;
            end
            rd_data_o[p*XLEN +: XLEN] = rdat;
            rd_busy_o[p]              = rbsy;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp: one bypassing and one non-bypassing
// instance share stimulus, so stored state is identical and only reads differ.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         reset;
    logic [9:0]   rd_addr_i;
    logic [1:0]   wr_en_i;
    logic [9:0]   wr_addr_i;
    logic [127:0] wr_data_i;
    logic         iss_en_i;
    logic [4:0]   iss_addr_i;
    logic [127:0] rd_data_b, rd_data_n;
    logic [1:0]   rd_busy_b, rd_busy_n;
    logic [31:0]  busy_b, busy_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i), .busy_o(busy_b)
    );

    regfile_mp #(.XLEN(64), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i), .busy_o(busy_n)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [63:0] wd0, wd1;
        logic        ie;
        logic [4:0]  ia, ra0, ra1;
        logic [63:0] e0b, e1b, e0n, e1n;
        logic [1:0]  ebb, ebn;
        logic [31:0] ebusy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
        input logic [63:0] wd0, input logic [63:0] wd1, input logic ie, input logic [4:0] ia,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [63:0] e0b, input logic [63:0] e1b, input logic [63:0] e0n, input logic [63:0] e1n,
        input logic [1:0] ebb, input logic [1:0] ebn, input logic [31:0] ebusy);
        vec_t v;
        v.rst = rst; v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
        v.e0b = e0b; v.e1b = e1b; v.e0n = e0n; v.e1n = e1n;
        v.ebb = ebb; v.ebn = ebn; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic [1:0] we, input logic [4:0] wa0,
                         input logic [4:0] wa1, input logic [63:0] wd0, input logic [63:0] wd1,
                         input logic ie, input logic [4:0] ia, input logic [4:0] ra0,
                         input logic [4:0] ra1);
        reset      = rst;
        wr_en_i    = we;
        wr_addr_i  = {wa1, wa0};
        wr_data_i  = {wd1, wd0};
        iss_en_i   = ie;
        iss_addr_i = ia;
        rd_addr_i  = {ra1, ra0};
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // Reset state reached with all write ports enabled during reset.
        drive(1'b0, 2'b11, 5'd1, 5'd2, '1, '1, 1'b1, 5'd1, 5'd1, 5'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd1, 5'd2);
        #2;
        n_vec++;
        chk("rst rd0_b", rd_data_b[63:0], 64'h0);
        chk("rst rd1_b", rd_data_b[127:64], 64'h0);
        chk("rst rd0_n", rd_data_n[63:0], 64'h0);
        chk("rst rd1_n", rd_data_n[127:64], 64'h0);
        chk("rst busy", {32'h0, busy_b}, 64'h0);
        chk("rst rbusy", {62'h0, rd_busy_b}, 64'h0);

        //            rst we    wa0 wa1 wd0             wd1        ie ia  ra0 ra1 e0b             e1b             e0n             e1n             ebb    ebn    ebusy
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     0, 0,  0,  5,  64'h0,          64'h0,          64'h0,          64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b01, 5, 0, 64'hDEAD_BEEF,  64'h0,     0, 0,  5,  1,  64'hDEAD_BEEF,  64'h0,          64'h0,          64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     0, 0,  5,  7,  64'hDEAD_BEEF,  64'h0,          64'hDEAD_BEEF,  64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b11, 7, 7, 64'h11,         64'h22,    0, 0,  5,  7,  64'hDEAD_BEEF,  64'h22,         64'hDEAD_BEEF,  64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     0, 0,  7,  7,  64'h22,         64'h22,         64'h22,         64'h22,         2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b11, 0, 0, 64'hFFFF,       64'hFFFF,  1, 0,  0,  0,  64'h0,          64'h0,          64'h0,          64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     0, 0,  0,  7,  64'h0,          64'h22,         64'h0,          64'h22,         2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     1, 3,  3,  0,  64'h0,          64'h0,          64'h0,          64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 3, 64'h0,          64'h9,     0, 0,  3,  5,  64'h9,          64'hDEAD_BEEF,  64'h0,          64'hDEAD_BEEF,  2'b00, 2'b01, 32'h8));
        tbl.push_back(mk(1, 2'b01, 3, 0, 64'h33,         64'h0,     1, 3,  3,  3,  64'h33,         64'h33,         64'h9,          64'h9,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     0, 0,  3,  4,  64'h33,         64'h0,          64'h33,         64'h0,          2'b01, 2'b01, 32'h8));
        tbl.push_back(mk(1, 2'b01, 4, 0, 64'h5,          64'h0,     1, 4,  4,  3,  64'h5,          64'h33,         64'h0,          64'h33,         2'b10, 2'b10, 32'h8));
        tbl.push_back(mk(0, 2'b01, 4, 0, 64'h6,          64'h0,     1, 5,  4,  3,  64'h5,          64'h33,         64'h5,          64'h33,         2'b11, 2'b11, 32'h18));
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     0, 0,  4,  3,  64'h0,          64'h0,          64'h0,          64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     0, 0,  5,  7,  64'h0,          64'h0,          64'h0,          64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b11, 1, 2, 64'hA1,         64'hB2,    0, 0,  2,  1,  64'hB2,         64'hA1,         64'h0,          64'h0,          2'b00, 2'b00, 32'h0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 64'h0,          64'h0,     0, 0,  1,  2,  64'hA1,         64'hB2,         64'hA1,         64'hB2,         2'b00, 2'b00, 32'h0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
                  tbl[i].ie, tbl[i].ia, tbl[i].ra0, tbl[i].ra1);
            #2;
            n_vec++;
            chk($sformatf("v%0d rd0_b", i), rd_data_b[63:0],   tbl[i].e0b);
            chk($sformatf("v%0d rd1_b", i), rd_data_b[127:64], tbl[i].e1b);
            chk($sformatf("v%0d rd0_n", i), rd_data_n[63:0],   tbl[i].e0n);
            chk($sformatf("v%0d rd1_n", i), rd_data_n[127:64], tbl[i].e1n);
            chk($sformatf("v%0d rbusy_b", i), {62'h0, rd_busy_b}, {62'h0, tbl[i].ebb});
            chk($sformatf("v%0d rbusy_n", i), {62'h0, rd_busy_n}, {62'h0, tbl[i].ebn});
            chk($sformatf("v%0d busy_b", i), {32'h0, busy_b}, {32'h0, tbl[i].ebusy});
            chk($sformatf("v%0d busy_n", i), {32'h0, busy_n}, {32'h0, tbl[i].ebusy});
        end

        // Re-issue while the old writer completes, then a plain completion on port 0.
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 5'd8, 5'd8, 5'd0);
        @(negedge clk);
        drive(1'b1, 2'b10, 5'd0, 5'd8, 64'h0, 64'h88, 1'b1, 5'd8, 5'd8, 5'd0);
        #2;
        n_vec++;
        chk("seq busy x8 set", {32'h0, busy_b}, 64'h100);
        chk("seq rbusy set+clr", {63'h0, rd_busy_b[0]}, 64'h1);
        chk("seq fwd x8", rd_data_b[63:0], 64'h88);
        chk("seq nofwd x8", rd_data_n[63:0], 64'h0);
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd8, 5'd0);
        #2;
        n_vec++;
        chk("seq busy kept", {32'h0, busy_b}, 64'h100);
        chk("seq x8 stored", rd_data_n[63:0], 64'h88);
        @(negedge clk);
        drive(1'b1, 2'b01, 5'd8, 5'd0, 64'h99, 64'h0, 1'b0, 5'd0, 5'd8, 5'd0);
        #2;
        n_vec++;
        chk("seq rbusy clr_b", {63'h0, rd_busy_b[0]}, 64'h0);
        chk("seq rbusy clr_n", {63'h0, rd_busy_n[0]}, 64'h1);
        chk("seq fwd x8 new", rd_data_b[63:0], 64'h99);
        @(negedge clk);
        drive(1'b1, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 5'd0, 5'd8, 5'd0);
        #2;
        n_vec++;
        chk("seq busy cleared", {32'h0, busy_b}, 64'h0);
        chk("seq x8 final", rd_data_n[63:0], 64'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
